md_sched: RTL

- Multi-cycle multiply/divide controller that owns the HI/LO register pair.
- Sits beside the E-stage ALU and accepts one mult/div/mthi/mtlo operation per start.
- Sequences a fixed-latency busy window and drives the stall request that holds an MD-class instruction in D while the unit is busy.
- Provides HI/LO read data for mfhi/mflo forwarding into the M stage.

---
 rtl/md_sched_pkg.sv | 39 +++
 rtl/md_sched_if.sv | 25 ++
 rtl/md_sched_arith.sv | 48 ++++
 rtl/md_sched.sv | 87 ++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies,
// FSM states and the arithmetic result payload.
package md_sched_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic            dz;
   } md_res_t;

   // Ops that open a multi-cycle busy window.
   function automatic logic is_multi(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage / hazard-unit facing bundle of the multiply/divide unit.
interface md_sched_if;
   import md_sched_pkg::*;

   logic            start;
   logic [2:0]      md_op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            md_use_D;
   logic            busy;
   logic            stall_md;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, md_op, rs_val, rt_val, md_use_D,
      input  busy, stall_md, hi, lo
   );

   modport slave (
      input  start, md_op, rs_val, rt_val, md_use_D,
      output busy, stall_md, hi, lo
   );

endinterface

// File: rtl/md_sched_arith.sv
// Combinational 64-bit mult/div result; dz flags a divide by zero.
module md_arith
   import md_sched_pkg::*;
(
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_rs,
   input  logic [XLEN-1:0] i_rt,
   output md_res_t         o_res_c
);

   logic signed [2*XLEN-1:0] w_sa, w_sb, w_sprod;
   logic        [2*XLEN-1:0] w_uprod;
   logic signed [XLEN-1:0]   w_sa32, w_sb32;

   assign w_sa    = {{XLEN{i_rs[XLEN-1]}}, i_rs};
   assign w_sb    = {{XLEN{i_rt[XLEN-1]}}, i_rt};
   assign w_sprod = w_sa * w_sb;
   assign w_uprod = {XLEN'(0), i_rs} * {XLEN'(0), i_rt};
   assign w_sa32  = i_rs;
   assign w_sb32  = i_rt;

   // SV signed division truncates toward zero; remainder follows the dividend.
   always_comb begin
      o_res_c = '0;
      case (i_op)
         MD_MULT:  {o_res_c.hi, o_res_c.lo} = w_sprod;
         MD_MULTU: {o_res_c.hi, o_res_c.lo} = w_uprod;
         MD_DIV: begin
            if (i_rt == '0) begin
               o_res_c.dz = 1'b1;
            end else begin
               o_res_c.lo = w_sa32 / w_sb32;
               o_res_c.hi = w_sa32 % w_sb32;
            end
         end
         MD_DIVU: begin
            if (i_rt == '0) begin
               o_res_c.dz = 1'b1;
            end else begin
               o_res_c.lo = i_rs / i_rt;
               o_res_c.hi = i_rs % i_rt;
            end
         end
         default: o_res_c = '0;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide controller: owns HI/LO, runs a fixed-latency busy window
// and raises the D-stage stall for MD-class instructions.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic    clk,
   input  logic    reset,
   md_sched_if.slave md
);

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0] r_hi, r_lo, r_p_hi, r_p_lo;
   logic            r_dz;
   logic            r_busy;

   md_res_t         w_res;
   logic            w_multi;

   md_arith u_arith (
      .i_op    (md.md_op),
      .i_rs    (md.rs_val),
      .i_rt    (md.rt_val),
      .o_res_c (w_res)
   );

   assign w_multi = md.start && is_multi(md.md_op);

   // Result is computed at start and parked in p_hi/p_lo until the window closes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_p_hi  <= '0;
         r_p_lo  <= '0;
         r_dz    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_multi) begin
                  r_p_hi  <= w_res.hi;
                  r_p_lo  <= w_res.lo;
                  r_dz    <= w_res.dz;
                  r_cnt   <= is_div(md.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end else if (md.start && (md.md_op == MD_MTHI)) begin
                  r_hi <= md.rs_val;
               end else if (md.start && (md.md_op == MD_MTLO)) begin
                  r_lo <= md.rs_val;
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  if (!r_dz) begin
                     r_hi <= r_p_hi;
                     r_lo <= r_p_lo;
                  end
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign md.busy     = r_busy;
   assign md.hi       = r_hi;
   assign md.lo       = r_lo;
   // Combinational so an MD instruction entering D alongside the start stalls at once.
   assign md.stall_md = md.md_use_D && (r_busy || w_multi);

endmodule
